// File: rtl/esdi_pkg.sv
// Shared definitions for the ESDI serial command/status interface:
// controller states, frame geometry, opcodes and the frame parity rule.
package esdi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RX_ACK = 3'd1,
    ST_RX_REL = 3'd2,
    ST_RX_REQ = 3'd3,
    ST_RESP   = 3'd4,
    ST_TX_REQ = 3'd5,
    ST_TX_ACK = 3'd6,
    ST_TX_REL = 3'd7
  } esdi_state_e;

  localparam int ESDI_FRAME_BITS = 17;

  localparam logic [3:0] OPC_REQ_STATUS = 4'h2;
  localparam logic [3:0] OPC_REQ_CONFIG = 4'h3;

  // Parity bit that makes the 17-bit frame carry an odd number of ones.
  function automatic logic odd_parity(input logic [15:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/esdi_sync2.sv
// Two-flop synchronizer for an idle-high asynchronous line; resets to 1.
module esdi_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Double-register the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/esdi_drive_cmd_responder.sv
// Drive-side ESDI serial command receiver and status/configuration responder
// working the TRANSFER REQ/ACK handshake.
module esdi_drive_cmd_responder
  import esdi_pkg::*;
#(
  parameter int unsigned ACK_DELAY   = 6,
  parameter int unsigned BIT_TIMEOUT = 1_000_000,
  parameter logic [3:0]  QUERY_OPC0  = OPC_REQ_STATUS,
  parameter logic [3:0]  QUERY_OPC1  = OPC_REQ_CONFIG
) (
  input  logic        csr_aclk,
  input  logic        csr_areset,
  input  logic        esdi_transfer_req,
  input  logic        esdi_command_data,
  output logic        esdi_transfer_ack,
  output logic        esdi_confstat_data,
  output logic        esdi_command_complete,
  output logic        esdi_attention,
  input  logic        attention,
  output logic        cmd_valid,
  output logic [15:0] cmd_data,
  output logic        cmd_parity_err,
  input  logic        cmd_done,
  input  logic        resp_valid,
  output logic        resp_ready,
  input  logic [15:0] resp_data,
  output logic        timeout
);

  localparam logic [4:0] LAST_BIT = 5'(ESDI_FRAME_BITS - 1);

  logic        req_sync_s, data_sync_s;
  esdi_state_e state_r, state_s;
  logic [4:0]  bit_cnt_r, bit_cnt_s;
  logic [31:0] cnt_r, cnt_s;
  logic [16:0] shift_in_r, shift_in_s;
  logic [16:0] shift_out_r, shift_out_s;
  logic        ack_r, ack_s, confstat_r, confstat_s, cc_r, cc_s, attn_r;
  logic        fin_pend_r, fin_pend_s, cmd_valid_r, cmd_valid_s;
  logic [15:0] cmd_data_r, cmd_data_s;
  logic        cmd_perr_r, cmd_perr_s, resp_ready_r, resp_ready_s;
  logic        timeout_r, timeout_s, abort_s, rx_perr_s, rx_query_s, tmo_hit_s;

  esdi_sync2 u_sync_req  (.clk(csr_aclk), .rst(csr_areset), .d(esdi_transfer_req), .q(req_sync_s));
  esdi_sync2 u_sync_data (.clk(csr_aclk), .rst(csr_areset), .d(esdi_command_data), .q(data_sync_s));

  assign rx_perr_s  = (odd_parity(shift_in_r[16:1]) != shift_in_r[0]);
  assign rx_query_s = !rx_perr_s && ((shift_in_r[16:13] == QUERY_OPC0) ||
                                     (shift_in_r[16:13] == QUERY_OPC1));
  assign tmo_hit_s  = (cnt_r >= (BIT_TIMEOUT - 32'd1));

  // Next-state and next-output logic of the handshake controller.
  always_comb begin
    state_s     = state_r;
    bit_cnt_s   = bit_cnt_r;
    shift_in_s  = shift_in_r;
    shift_out_s = shift_out_r;
    ack_s       = ack_r;
    confstat_s  = confstat_r;
    fin_pend_s  = 1'b0;
    cmd_valid_s = 1'b0;
    cmd_data_s  = cmd_data_r;
    cmd_perr_s  = cmd_perr_r;
    abort_s     = 1'b0;
    cnt_s       = 32'd0;

    // A cmd_done coinciding with cmd_valid belongs to the previous command.
    if ((cmd_done && !cmd_valid_r) || (fin_pend_r && rx_perr_s)) begin
      cc_s = 1'b0;
    end else begin
      cc_s = cc_r;
    end

    if (fin_pend_r) begin
      cmd_valid_s = 1'b1;
      cmd_data_s  = shift_in_r[16:1];
      cmd_perr_s  = rx_perr_s;
    end else begin
      cmd_valid_s = 1'b0;
    end

    case (state_r)
      ST_IDLE: begin
        bit_cnt_s = 5'd0;
        if (!req_sync_s) begin
          shift_in_s = {shift_in_r[15:0], ~data_sync_s};
          cc_s       = 1'b1;
          state_s    = ST_RX_ACK;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RX_ACK: begin
        if (cnt_r == (ACK_DELAY - 32'd1)) begin
          ack_s   = 1'b0;
          state_s = ST_RX_REL;
        end else begin
          state_s = ST_RX_ACK;
        end
      end
      ST_RX_REL: begin
        if (req_sync_s) begin
          ack_s = 1'b1;
          if (bit_cnt_r == LAST_BIT) begin
            bit_cnt_s  = 5'd0;
            fin_pend_s = 1'b1;
            state_s    = rx_query_s ? ST_RESP : ST_IDLE;
          end else begin
            bit_cnt_s = bit_cnt_r + 5'd1;
            state_s   = ST_RX_REQ;
          end
        end else begin
          abort_s = tmo_hit_s;
        end
      end
      ST_RX_REQ: begin
        if (!req_sync_s) begin
          shift_in_s = {shift_in_r[15:0], ~data_sync_s};
          state_s    = ST_RX_ACK;
        end else begin
          abort_s = tmo_hit_s;
        end
      end
      ST_RESP: begin
        if (resp_valid && resp_ready_r) begin
          shift_out_s = {resp_data, odd_parity(resp_data)};
          bit_cnt_s   = 5'd0;
          state_s     = ST_TX_REQ;
        end else begin
          abort_s = tmo_hit_s;
        end
      end
      ST_TX_REQ: begin
        if (!req_sync_s) begin
          confstat_s = ~shift_out_r[16];
          state_s    = ST_TX_ACK;
        end else begin
          abort_s = tmo_hit_s;
        end
      end
      ST_TX_ACK: begin
        if (cnt_r == (ACK_DELAY - 32'd1)) begin
          ack_s   = 1'b0;
          state_s = ST_TX_REL;
        end else begin
          abort_s = tmo_hit_s;
        end
      end
      ST_TX_REL: begin
        if (req_sync_s) begin
          ack_s       = 1'b1;
          shift_out_s = {shift_out_r[15:0], 1'b0};
          if (bit_cnt_r == LAST_BIT) begin
            bit_cnt_s  = 5'd0;
            confstat_s = 1'b1;
            cc_s       = 1'b0;
            state_s    = ST_IDLE;
          end else begin
            bit_cnt_s = bit_cnt_r + 5'd1;
            state_s   = ST_TX_REQ;
          end
        end else begin
          abort_s = tmo_hit_s;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if (abort_s) begin
      state_s    = ST_IDLE;
      ack_s      = 1'b1;
      confstat_s = 1'b1;
      cc_s       = 1'b0;
      bit_cnt_s  = 5'd0;
    end else begin
      bit_cnt_s = bit_cnt_s;
    end

    // One counter serves both the ACK delay and the per-state watchdog.
    if ((state_s != state_r) || (state_r == ST_IDLE)) begin
      cnt_s = 32'd0;
    end else begin
      cnt_s = cnt_r + 32'd1;
    end

    resp_ready_s = (state_s == ST_RESP);
    timeout_s    = abort_s;
  end

  // State and registered-output update.
  always_ff @(posedge csr_aclk or posedge csr_areset) begin
    if (csr_areset) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= 5'd0;
      cnt_r        <= 32'd0;
      shift_in_r   <= 17'd0;
      shift_out_r  <= 17'd0;
      ack_r        <= 1'b1;
      confstat_r   <= 1'b1;
      cc_r         <= 1'b0;
      fin_pend_r   <= 1'b0;
      cmd_valid_r  <= 1'b0;
      cmd_data_r   <= 16'd0;
      cmd_perr_r   <= 1'b0;
      resp_ready_r <= 1'b0;
      timeout_r    <= 1'b0;
      attn_r       <= 1'b1;
    end else begin
      state_r      <= state_s;
      bit_cnt_r    <= bit_cnt_s;
      cnt_r        <= cnt_s;
      shift_in_r   <= shift_in_s;
      shift_out_r  <= shift_out_s;
      ack_r        <= ack_s;
      confstat_r   <= confstat_s;
      cc_r         <= cc_s;
      fin_pend_r   <= fin_pend_s;
      cmd_valid_r  <= cmd_valid_s;
      cmd_data_r   <= cmd_data_s;
      cmd_perr_r   <= cmd_perr_s;
      resp_ready_r <= resp_ready_s;
      timeout_r    <= timeout_s;
      attn_r       <= ~attention;
    end
  end

  assign esdi_transfer_ack     = ack_r;
  assign esdi_confstat_data    = confstat_r;
  assign esdi_command_complete = cc_r;
  assign esdi_attention        = attn_r;
  assign cmd_valid             = cmd_valid_r;
  assign cmd_data              = cmd_data_r;
  assign cmd_parity_err        = cmd_perr_r;
  assign resp_ready            = resp_ready_r;
  assign timeout               = timeout_r;

endmodule
